// File: rtl/rng_arbiter.sv
// rng_arbiter: shared 16-bit LFSR random source. A small prefetch FIFO keeps
// words ready, and a round-robin arbiter hands one word per grant to NUM_REQ
// consumers. seed_load reseeds the LFSR at runtime and flushes the FIFO.
// Optional build macro RNG_ARB_STATS_EN adds draw_cnt and starve_flag outputs.
module rng_arbiter #(
  parameter int              NUM_REQ = 4,
  parameter int              DEPTH   = 4,
  parameter logic [15:0]     SEED    = 16'hFFFF,
  localparam int             IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int             LW      = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [15:0]        rnd_data,
  output logic [IDW-1:0]     rnd_id,
  input  logic               seed_load,
  input  logic [15:0]        seed_data,
  output logic [LW-1:0]      fifo_level
`ifdef RNG_ARB_STATS_EN
  ,
  output logic [31:0]        draw_cnt,
  output logic               starve_flag
`endif
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
  localparam logic [0:0]    S_FLUSH = 1'b0;
  localparam logic [0:0]    S_RUN   = 1'b1;

  logic [0:0]         r_state;
  logic [15:0]        r_lfsr;
  logic [15:0]        r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [LW-1:0]      r_level;
  logic [IDW-1:0]     r_rr_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [15:0]        r_data;
  logic [IDW-1:0]     r_id;

  logic [15:0]        w_next;
  logic [NUM_REQ-1:0] w_elig;
  logic               w_found;
  logic [IDW-1:0]     w_idx;
  int                 w_cand;
  logic               w_run;
  logic               w_pop;
  logic               w_push;

  // Sixteen Fibonacci steps of the x^16+x^14+x^13+x^11 LFSR in one cycle.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < 16; i++) begin
      v = {v[14:0], v[10] ^ v[12] ^ v[13] ^ v[15]};
    end
    return v;
  endfunction

  assign w_next = lfsr_next(r_lfsr);

  // Round-robin search from the pointer+1, skipping anyone granted last cycle.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and default every output
    // first, so the loop reads its own updates and no latch is inferred.
    w_elig  = req & ~r_gnt;
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = int'(r_rr_ptr) + i;
      if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
      if (!w_found && w_elig[w_cand[IDW-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_cand[IDW-1:0];
      end
    end
  end

  assign w_run  = (r_state == S_RUN);
  assign w_pop  = w_run && (r_level != '0) && w_found;
  assign w_push = w_run && ((r_level != LVL_MAX) || w_pop);

  // FSM, LFSR and FIFO bookkeeping; reseed overrides push and pop.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state  <= S_FLUSH;
      r_lfsr   <= SEED;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (seed_load) begin
      r_state  <= S_FLUSH;
      r_lfsr   <= (seed_data == 16'h0000) ? SEED : seed_data;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_state <= S_RUN;
      if (w_push) begin
        r_lfsr   <= w_next;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
    end
  end

  // FIFO storage; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; stale words are never read
    // because the level counter is cleared instead.
    if (!rst && !seed_load && w_push) r_mem[r_wr_ptr] <= w_next;
  end

  // Registered grant, word and id; pointer follows the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt    <= '0;
      r_data   <= '0;
      r_id     <= '0;
      r_rr_ptr <= IDW'(NUM_REQ - 1);
    end else if (seed_load) begin
      r_gnt <= '0;
    end else if (w_pop) begin
      r_gnt    <= NUM_REQ'(1) << w_idx;
      r_data   <= r_mem[r_rd_ptr];
      r_id     <= w_idx;
      r_rr_ptr <= w_idx;
    end else begin
      r_gnt <= '0;
    end
  end

  assign gnt        = r_gnt;
  assign rnd_valid  = |r_gnt;
  assign rnd_data   = r_data;
  assign rnd_id     = r_id;
  assign fifo_level = r_level;

`ifdef RNG_ARB_STATS_EN
  localparam int            STARVE_LIM = NUM_REQ * 2 + DEPTH + 2;
  localparam int            CW         = $clog2(STARVE_LIM + 1) + 1;
  localparam logic [CW-1:0] WAIT_LIM   = CW'(STARVE_LIM);

  logic [31:0]   r_draw_cnt;
  logic          r_starve;
  logic [CW-1:0] r_wait [NUM_REQ];

  // Grant counter; only rst clears it, reseed does not.
  always_ff @(posedge clk) begin
    if (rst) r_draw_cnt <= '0;
    else     r_draw_cnt <= r_draw_cnt + {31'b0, rnd_valid};
  end

  // Per-requester wait counters feeding a sticky starvation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) r_wait[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && !r_gnt[i]) begin
          if (r_wait[i] == WAIT_LIM) r_starve <= 1'b1;
          else                       r_wait[i] <= r_wait[i] + CW'(1);
        end else begin
          r_wait[i] <= '0;
        end
      end
    end
  end

  assign draw_cnt    = r_draw_cnt;
  assign starve_flag = r_starve;
`endif

endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: directed vector table, hand-written corner sequences and a
// random phase, all compared against a queue-based reference model.
module tb_rng_arbiter;

  localparam int          N    = 4;
  localparam int          D    = 4;
  localparam logic [15:0] SEED = 16'hFFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          rnd_valid;
  logic [15:0]   rnd_data;
  logic [1:0]    rnd_id;
  logic          seed_load;
  logic [15:0]   seed_data;
  logic [2:0]    fifo_level;
`ifdef RNG_ARB_STATS_EN
  logic [31:0]   draw_cnt;
  logic          starve_flag;
`endif

  rng_arbiter #(.NUM_REQ(N), .DEPTH(D), .SEED(SEED)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .rnd_valid  (rnd_valid),
    .rnd_data   (rnd_data),
    .rnd_id     (rnd_id),
    .seed_load  (seed_load),
    .seed_data  (seed_data),
    .fifo_level (fifo_level)
`ifdef RNG_ARB_STATS_EN
    ,
    .draw_cnt   (draw_cnt),
    .starve_flag(starve_flag)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_lfsr = SEED;
  logic [15:0] m_q [$];
  bit          m_flush = 1'b1;
  int          m_ptr = N - 1;
  int          m_gidx = -1;
  logic [15:0] m_data = '0;
  int          m_id = 0;
  logic [31:0] m_draw = '0;

  // One word = sixteen shifts with feedback from taps 15,13,12,10.
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    logic [15:0] v;
    v = s;
    repeat (16) v = {v[14:0], ^(v & 16'hB400)};
    return v;
  endfunction

  task automatic model_step(input bit r, input bit sl, input logic [15:0] sd,
                            input logic [N-1:0] rq);
    int win;
    win = -1;
    if (r) m_draw = '0;
    else if (m_gidx >= 0) m_draw = m_draw + 32'd1;
    if (r) begin
      m_lfsr = SEED; m_q.delete(); m_flush = 1'b1; m_ptr = N - 1;
      m_gidx = -1; m_data = '0; m_id = 0;
    end else if (sl) begin
      m_lfsr = (sd == 16'h0) ? SEED : sd; m_q.delete(); m_flush = 1'b1; m_gidx = -1;
    end else if (m_flush) begin
      m_flush = 1'b0; m_gidx = -1;
    end else begin
      if (m_q.size() > 0)
        for (int i = 1; i <= N; i++) begin
          int k;
          k = (m_ptr + i) % N;
          if (win < 0 && rq[k] && k != m_gidx) win = k;
        end
      if (win >= 0) begin
        m_data = m_q.pop_front(); m_id = win; m_ptr = win;
      end
      if (m_q.size() < D) begin
        m_lfsr = ref_next(m_lfsr);
        m_q.push_back(m_lfsr);
      end
      m_gidx = win;
    end
  endtask

  // Drive one cycle, advance the model, sample 1 ns after the edge, compare.
  task automatic apply(input bit r, input bit sl, input logic [15:0] sd, input logic [N-1:0] rq);
    logic [N-1:0] eg;
    rst = r; seed_load = sl; seed_data = sd; req = rq;
    model_step(r, sl, sd, rq);
    @(posedge clk);
    #1;
    eg = (m_gidx >= 0) ? N'(1) << m_gidx : '0;
    check("mdl_gnt", gnt, eg);
    check("mdl_valid", rnd_valid, (m_gidx >= 0));
    check("mdl_level", fifo_level, m_q.size());
    if (m_gidx >= 0 || r) begin
      check("mdl_data", rnd_data, m_data);
      check("mdl_id", rnd_id, m_id);
    end
`ifdef RNG_ARB_STATS_EN
    check("mdl_draw_cnt", draw_cnt, m_draw);
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit           rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    int           lvl;
    bit           chk_d;
    logic [15:0]  data;
    int           id;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input bit r, input logic [N-1:0] rq, input logic [N-1:0] g,
                              input int lvl, input bit cd, input logic [15:0] d, input int id);
    vec_t v;
    v.rst = r; v.req = rq; v.gnt = g; v.lvl = lvl; v.chk_d = cd; v.data = d; v.id = id;
    tbl.push_back(v);
  endfunction

  initial begin
    int ng;
    bit hit;
    bit prev;

    rst = 1'b1; req = '0; seed_load = 1'b0; seed_data = '0;

    // Reset 3 cycles, fill, two single requests.
    repeat (3) add(1, 4'b0000, 4'b0000, 0, 1, 16'h0000, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 1, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 2, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 3, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 4, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 4, 0, 0, 0);
    add(0, 4'b0001, 4'b0001, 4, 1, 16'h001B, 0);
    add(0, 4'b0000, 4'b0000, 4, 0, 0, 0);
    add(0, 4'b0001, 4'b0001, 4, 1, 16'h03CF, 0);
    add(0, 4'b0000, 4'b0000, 4, 0, 0, 0);
    // Fresh reset, fill, all four requesting: rotation 0,1,2,3,0,1,2,3.
    add(1, 4'b0000, 4'b0000, 0, 1, 16'h0000, 0);
    add(0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 1, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 2, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 3, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 4, 0, 0, 0);
    add(0, 4'b0000, 4'b0000, 4, 0, 0, 0);
    add(0, 4'b1111, 4'b0001, 4, 1, 16'h001B, 0);
    add(0, 4'b1111, 4'b0010, 4, 1, 16'h03CF, 1);
    add(0, 4'b1111, 4'b0100, 4, 0, 0, 2);
    add(0, 4'b1111, 4'b1000, 4, 0, 0, 3);
    add(0, 4'b1111, 4'b0001, 4, 0, 0, 0);
    add(0, 4'b1111, 4'b0010, 4, 0, 0, 1);
    add(0, 4'b1111, 4'b0100, 4, 0, 0, 2);
    add(0, 4'b1111, 4'b1000, 4, 0, 0, 3);
    add(0, 4'b0000, 4'b0000, 4, 0, 0, 0);
    // Request from the first cycle after release: grant on the third edge.
    add(1, 4'b0000, 4'b0000, 0, 1, 16'h0000, 0);
    add(0, 4'b0001, 4'b0000, 0, 0, 0, 0);
    add(0, 4'b0001, 4'b0000, 1, 0, 0, 0);
    add(0, 4'b0001, 4'b0001, 1, 1, 16'h001B, 0);
    add(0, 4'b0000, 4'b0000, 2, 0, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, 1'b0, 16'h0, tbl[i].req);
      check($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      check($sformatf("tbl%0d_valid", i), rnd_valid, |tbl[i].gnt);
      check($sformatf("tbl%0d_level", i), fifo_level, tbl[i].lvl);
      if (tbl[i].chk_d) check($sformatf("tbl%0d_data", i), rnd_data, tbl[i].data);
      if (|tbl[i].gnt) check($sformatf("tbl%0d_id", i), rnd_id, tbl[i].id);
    end

    // Lone requester 2 held 10 cycles: alternate-cycle grants only.
    repeat (4) apply(0, 0, 16'h0, 4'b0000);
    ng = 0; prev = 1'b0;
    for (int c = 0; c < 10; c++) begin
      apply(0, 0, 16'h0, 4'b0100);
      if (rnd_valid) begin
        ng++;
        check("solo_gnt", gnt, 4'b0100);
        check("solo_id", rnd_id, 2);
        check("solo_b2b", prev, 1'b0);
      end
      prev = rnd_valid;
    end
    check("solo_count", ng, 5);

    // Reseed with zero, then with FFFF, while requester 1 is held.
    for (int s = 0; s < 2; s++) begin
      logic [15:0] sd;
      sd = (s == 0) ? 16'h0000 : 16'hFFFF;
      repeat (3) apply(0, 0, 16'h0, 4'b0010);
      apply(0, 1, sd, 4'b0010);
      check("seed_level", fifo_level, 0);
      check("seed_gnt", gnt, 4'b0000);
      hit = 1'b0;
      for (int c = 0; c < 10 && !hit; c++) begin
        apply(0, 0, 16'h0, 4'b0010);
        hit = rnd_valid;
      end
      check("seed_grant_seen", hit, 1'b1);
      check("seed_data", rnd_data, 16'h001B);
      check("seed_id", rnd_id, 1);
    end

    // Reset in the middle of a 4-requester burst.
    repeat (5) apply(0, 0, 16'h0, 4'b1111);
    apply(1, 0, 16'h0, 4'b1111);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_valid", rnd_valid, 1'b0);
    check("rst_level", fifo_level, 0);
`ifdef RNG_ARB_STATS_EN
    check("rst_draw", draw_cnt, 0);
    check("rst_starve", starve_flag, 1'b0);
`endif
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      apply(0, 0, 16'h0, 4'b1111);
      hit = rnd_valid;
    end
    check("rst_grant_seen", hit, 1'b1);
    check("rst_first_gnt", gnt, 4'b0001);
    check("rst_first_data", rnd_data, 16'h001B);

    // Random traffic with occasional reseed and reset.
    for (int c = 0; c < 2000; c++) begin
      bit          r;
      bit          sl;
      logic [15:0] sd;
      r  = ($urandom_range(0, 199) == 0);
      sl = ($urandom_range(0, 59) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      apply(r, sl, sd, N'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
- Shared 16-bit LFSR random-number source with a prefetch buffer and a round-robin arbiter.
- Serves NUM_REQ consumers, e.g. dropout masks, weight init and stochastic rounding in tensor units.
- Replaces per-unit RNG instances; supports runtime reseed.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DEPTH, 4, prefetch FIFO depth in words (power of 2, >=2)
SEED, 16'hFFFF, reset seed and substitute for a zero seed_data (must be nonzero)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  level request per requester
gnt  out  NUM_REQ  registered one-hot grant, 1-cycle pulse
rnd_valid  out  1  equals |gnt
rnd_data  out  16  random word, valid while rnd_valid
rnd_id  out  IDW  index of granted requester, IDW = max(1, clog2(NUM_REQ))
seed_load  in  1  reseed strobe
seed_data  in  16  new seed
fifo_level  out  clog2(DEPTH)+1  current prefetch occupancy

Behaviour:
- Reset (rst=1 at a posedge):
  - gnt=0, rnd_valid=0, rnd_data=0, rnd_id=0, fifo_level=0.
  - LFSR state=SEED, RR pointer=NUM_REQ-1 (index 0 has first priority), FSM=S_FLUSH.
  - rst mid-operation discards the FIFO contents and any pending arbitration.
- LFSR step function next(s): repeat 16 times { fb = s[10]^s[12]^s[13]^s[15]; s = {s[14:0],fb} }. Computed combinationally in one clock.
- FSM:
  - S_FLUSH lasts exactly one cycle: no push, no grant; then S_RUN.
  - S_RUN: push and arbitration are active.
  - seed_load in any state returns the FSM to S_FLUSH.
- Fill, in S_RUN:
  - If fifo_level<DEPTH, or a pop occurs the same cycle, push next(lfsr) and set lfsr<=next(lfsr).
  - Push and pop in the same cycle leave the level unchanged.
  - The FIFO never overflows.
- Arbitration, in S_RUN with fifo_level>0:
  - Eligible set = req & ~gnt. The mask stops a requester from being regranted while it reacts to its grant.
  - Search starts at pointer+1 and wraps modulo NUM_REQ. The first eligible index wins.
  - On the next cycle: gnt[idx]=1, rnd_id=idx, rnd_data=FIFO head (popped), pointer<=idx.
  - If the eligible set is empty or the FIFO is empty: no grant, pointer unchanged.
- Latency and throughput:
  - req high at edge t with data available gives gnt in cycle t+1.
  - Aggregate throughput is 1 word/cycle with >=2 requesters active.
  - A single continuously-requesting requester gets 1 word every 2 cycles.
- Requester rule: drop req in the cycle after gnt if no more words are wanted. Words are never duplicated across grants.
- Reseed (seed_load=1 at an edge):
  - lfsr<=seed_data, or SEED if seed_data==0 (avoids lock-up).
  - FIFO flushed (level 0); no new grant issued at that edge.
  - A gnt already registered in the current cycle completes with its old data.
  - seed_load has priority over push and pop. rst has priority over seed_load.
- The first word after reset or reseed with seed s is next(s). SEED=16'hFFFF yields 16'h001B, then 16'h03CF.

Optional Feature:
- Macro RNG_ARB_STATS_EN.
- When defined, adds output draw_cnt [31:0]:
  - Total grants issued.
  - +1 per cycle with rnd_valid=1, wraps at 2^32.
  - Cleared by rst only, not by seed_load.
  - Also adds output starve_flag, a sticky flag set if any requester holds req for more than NUM_REQ*2+DEPTH+2 consecutive cycles without a grant. Cleared by rst.
- When undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset 3 cycles, release, wait 6 cycles (fifo_level=4), pulse req[0] 1 cycle -> next cycle gnt=4'b0001, rnd_id=0, rnd_data=16'h001B. Second single request -> 16'h03CF.
- req=4'b1111 held 8 cycles after fill -> gnt rotates 0,1,2,3,0,1,2,3 one per cycle. rnd_data starts 16'h001B,16'h03CF. fifo_level stays 4. No index is repeated back-to-back.
- Only req[2] held 10 cycles -> gnt[2] on alternate cycles only (5 grants); rnd_id=2 each time.
- Request on the first cycle after reset release -> no grant until the FIFO is nonempty. First grant carries 16'h001B with gnt at cycle 3 after release (S_FLUSH, push, grant).
- seed_load with seed_data=16'h0000 while req[1] is held -> fifo_level=0 next cycle, no grant that edge. Next grant to 1 carries 16'h001B (SEED substituted). Repeat with 16'hFFFF -> same value.
- rst asserted for 1 cycle during a 4-requester burst -> next cycle gnt=0, rnd_valid=0, fifo_level=0. The sequence restarts at 16'h001B, granted to requester 0. With RNG_ARB_STATS_EN: draw_cnt=0 after reset, then equals the number of grant pulses counted.
